// File: rtl/mul_unit_sched.sv
// mul_unit_sched: one iterative 32x32 shift-add multiplier (RV32M MUL, MULH,
// MULHSU, MULHU) shared round-robin between p_num_req issue requesters.
// One op in flight. The result returns with its seq tag and requester id.
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   req_val/req_rdy        per-requester handshake (req_rdy one-hot or zero)
//   req_op1/req_op2        32-bit operands, requester i at [32*i+:32]
//   req_func               2 bits per requester: 0=MUL 1=MULH 2=MULHSU 3=MULHU
//   req_seq_num            per-requester sequence tag
//   resp_val/resp_rdy      result handshake
//   resp_data/seq_num/id   result word, its tag and originating requester

// Per-requester operand conditioning. Produces operand magnitudes and the
// result sign, so the shared datapath only needs to multiply unsigned values.
module mul_unit_sched_lane (
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic [1:0]  func_i,
  output logic [31:0] mag1_o,
  output logic [31:0] mag2_o,
  output logic        neg_o
);
  logic s1, s2;
  // MUL takes the unsigned path because the low product word does not depend on sign.
  assign s1     = ((func_i == 2'd1) || (func_i == 2'd2)) && op1_i[31];
  assign s2     = (func_i == 2'd1) && op2_i[31];
  assign mag1_o = s1 ? (~op1_i + 32'd1) : op1_i;
  assign mag2_o = s2 ? (~op2_i + 32'd1) : op2_i;
  assign neg_o  = s1 ^ s2;
endmodule

module mul_unit_sched #(
  parameter int p_num_req      = 2,
  parameter int p_seq_num_bits = 5,
  localparam int ID_W = (p_num_req > 1) ? $clog2(p_num_req) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [p_num_req-1:0]                  req_val,
  output logic [p_num_req-1:0]                  req_rdy,
  input  logic [32*p_num_req-1:0]               req_op1,
  input  logic [32*p_num_req-1:0]               req_op2,
  input  logic [2*p_num_req-1:0]                req_func,
  input  logic [p_seq_num_bits*p_num_req-1:0]   req_seq_num,
  output logic                                  resp_val,
  input  logic                                  resp_rdy,
  output logic [31:0]                           resp_data,
  output logic [p_seq_num_bits-1:0]             resp_seq_num,
  output logic [ID_W-1:0]                       resp_id
);
  localparam int SW = p_seq_num_bits;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [63:0]         mcand_q, mcand_d;
  logic [31:0]         mplier_q, mplier_d;
  logic [63:0]         acc_q, acc_d;
  logic [1:0]          func_q, func_d;
  logic                neg_q, neg_d;
  logic [SW-1:0]       seq_q, seq_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                rval_q, rval_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [SW-1:0]       rseq_q, rseq_d;
  logic [ID_W-1:0]     rid_q, rid_d;

  logic [p_num_req-1:0][31:0] mag1, mag2;
  logic [p_num_req-1:0]       negv;

  for (genvar g = 0; g < p_num_req; g++) begin : g_lane
    mul_unit_sched_lane u_lane (
      .op1_i  (req_op1[32*g +: 32]),
      .op2_i  (req_op2[32*g +: 32]),
      .func_i (req_func[2*g +: 2]),
      .mag1_o (mag1[g]),
      .mag2_o (mag2[g]),
      .neg_o  (negv[g])
    );
  end

  // Round-robin grant: scan from the highest offset down so that the lowest
  // offset from rr_ptr that has req_val set is the last one written.
  logic            gnt_vld;
  logic [ID_W-1:0] gnt_id;
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int k = p_num_req - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(rr_ptr_q) + k) % p_num_req;
      if (req_val[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = ID_W'(idx);
      end
    end
  end

  // req_rdy is gated by rst_n so that no requester sees an accept while reset is held.
  always_comb begin
    req_rdy = '0;
    if (rst_n && (state_q == IDLE) && gnt_vld) req_rdy[gnt_id] = 1'b1;
  end

  logic [63:0] prod;
  assign prod = neg_q ? (~acc_q + 64'd1) : acc_q;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    func_d   = func_q;
    neg_d    = neg_q;
    seq_d    = seq_q;
    id_d     = id_q;
    rval_d   = rval_q;
    rdata_d  = rdata_q;
    rseq_d   = rseq_q;
    rid_d    = rid_q;
    case (state_q)
      IDLE: if (gnt_vld) begin
        mcand_d  = {32'd0, mag1[gnt_id]};
        mplier_d = mag2[gnt_id];
        acc_d    = '0;
        cnt_d    = '0;
        func_d   = req_func[2*gnt_id +: 2];
        seq_d    = req_seq_num[SW*gnt_id +: SW];
        id_d     = gnt_id;
        neg_d    = negv[gnt_id];
        state_d  = CALC;
      end
      CALC: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = DONE;
      end
      DONE: begin
        // The first DONE cycle applies the sign and registers the result. The
        // result then stays in registers, stable under backpressure.
        if (!rval_q) begin
          rdata_d = (func_q == 2'd0) ? prod[31:0] : prod[63:32];
          rseq_d  = seq_q;
          rid_d   = id_q;
          rval_d  = 1'b1;
        end else if (resp_rdy) begin
          rval_d   = 1'b0;
          rr_ptr_d = ID_W'((int'(id_q) + 1) % p_num_req);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      func_q   <= '0;
      neg_q    <= 1'b0;
      seq_q    <= '0;
      id_q     <= '0;
      rval_q   <= 1'b0;
      rdata_q  <= '0;
      rseq_q   <= '0;
      rid_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      func_q   <= func_d;
      neg_q    <= neg_d;
      seq_q    <= seq_d;
      id_q     <= id_d;
      rval_q   <= rval_d;
      rdata_q  <= rdata_d;
      rseq_q   <= rseq_d;
      rid_q    <= rid_d;
    end
  end

  assign resp_val     = rval_q;
  assign resp_data    = rdata_q;
  assign resp_seq_num = rseq_q;
  assign resp_id      = rid_q;
endmodule

// File: tb/tb_mul_unit_sched.sv
// Testbench for mul_unit_sched with two requesters. It compares the design
// against a reference model built on 64-bit signed products and an abstract
// round-robin pointer.
module tb_mul_unit_sched;
  logic        clk, rst_n;
  logic [1:0]  req_val, req_rdy;
  logic [63:0] req_op1, req_op2;
  logic [3:0]  req_func;
  logic [9:0]  req_seq_num;
  logic        resp_val, resp_rdy;
  logic [31:0] resp_data;
  logic [4:0]  resp_seq_num;
  logic [0:0]  resp_id;

  mul_unit_sched #(.p_num_req(2), .p_seq_num_bits(5)) dut (
    .clk(clk), .rst_n(rst_n), .req_val(req_val), .req_rdy(req_rdy),
    .req_op1(req_op1), .req_op2(req_op2), .req_func(req_func),
    .req_seq_num(req_seq_num), .resp_val(resp_val), .resp_rdy(resp_rdy),
    .resp_data(resp_data), .resp_seq_num(resp_seq_num), .resp_id(resp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  // Model state: the operands driven on each lane and the round-robin pointer.
  logic [31:0] a_m [2];
  logic [31:0] b_m [2];
  logic [1:0]  f_m [2];
  logic [4:0]  s_m [2];
  int          rr_m;

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] f);
    logic signed [63:0] sa, sb, p;
    sa = (f == 2'd1 || f == 2'd2) ? {{32{a[31]}}, a} : {32'd0, a};
    sb = (f == 2'd1) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = sa * sb;
    return (f == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  task automatic set_lane(input int r, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] f, input logic [4:0] s);
    a_m[r] = a; b_m[r] = b; f_m[r] = f; s_m[r] = s;
    req_op1[32*r +: 32]   = a;
    req_op2[32*r +: 32]   = b;
    req_func[2*r +: 2]    = f;
    req_seq_num[5*r +: 5] = s;
  endtask

  // Runs one op: arbitration check, latency check, result check, optional
  // backpressure of bp cycles, then the response handshake.
  task automatic run_op(input logic [1:0] vmask, input int bp,
                        output logic [31:0] obs, output int gid);
    int n;
    logic [31:0] d0;
    logic [4:0]  s0;
    logic        i0;
    gid = vmask[rr_m] ? rr_m : 1 - rr_m;
    resp_rdy = (bp == 0);
    req_val  = vmask;
    @(negedge clk);
    chk("grant", req_rdy, 2'b01 << gid);
    @(posedge clk); #1;
    req_val = 2'b00;
    n = 0;
    while (!resp_val && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, 33);
    obs = resp_data;
    chk("data", resp_data, ref_mul(a_m[gid], b_m[gid], f_m[gid]));
    chk("seq", resp_seq_num, s_m[gid]);
    chk("id", resp_id, gid);
    if (bp > 0) begin
      d0 = resp_data; s0 = resp_seq_num; i0 = resp_id[0];
      req_val = 2'b11;
      for (int c = 0; c < bp; c++) begin
        @(negedge clk);
        chk("bp_val", resp_val, 1'b1);
        chk("bp_hold", {resp_data, resp_seq_num, i0 ^ resp_id[0]}, {d0, s0, 1'b0});
        chk("bp_rdy", req_rdy, 2'b00);
      end
      req_val  = 2'b00;
      resp_rdy = 1'b1;
    end
    @(posedge clk); #1;
    chk("resp_drop", resp_val, 1'b0);
    rr_m = (gid + 1) % 2;
  endtask

  logic [31:0] obs;
  int          gid;

  // Directed cases with spec-given expected results: {op1, op2, func, expected}.
  logic [31:0] dir_a [10] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'h0, 32'h1234_5678};
  logic [31:0] dir_b [10] = '{32'd3, 32'd3, 32'd2, 32'd2, 32'h8000_0000, 32'hFFFF_FFFF,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h0};
  logic [1:0]  dir_f [10] = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd1, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  logic [31:0] dir_e [10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'h0000_0001,
                              32'h4000_0000, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
                              32'h0, 32'h0};

  initial begin
    logic stale;
    rst_n = 1'b0; req_val = 2'b11; resp_rdy = 1'b1;
    req_op1 = '0; req_op2 = '0; req_func = '0; req_seq_num = '0;
    rr_m = 0;
    repeat (3) @(posedge clk); #1;
    chk("rst_req_rdy", req_rdy, 2'b00);
    chk("rst_resp_val", resp_val, 1'b0);
    chk("rst_resp_fields", {resp_data, resp_seq_num, resp_id}, '0);
    req_val = 2'b00;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_rdy", req_rdy, 2'b00);

    // A request that drops before the edge must not be consumed.
    set_lane(1, 32'd5, 32'd5, 2'd0, 5'd9);
    req_val = 2'b10;
    @(negedge clk);
    chk("drop_grant", req_rdy, 2'b10);
    req_val = 2'b00;
    @(posedge clk); #1;

    set_lane(0, 32'd7, 32'd6, 2'd0, 5'd3);
    run_op(2'b01, 0, obs, gid);
    chk("mul7x6", obs, 32'd42);

    for (int i = 0; i < 10; i++) begin
      int r;
      r = $urandom_range(0, 1);
      set_lane(r, dir_a[i], dir_b[i], dir_f[i], 5'(i + 10));
      run_op(2'b01 << r, 0, obs, gid);
      chk("directed", obs, dir_e[i]);
    end

    set_lane(1, 32'h0001_0003, 32'hFFFF_0007, 2'd2, 5'd21);
    run_op(2'b10, 10, obs, gid);

    // Reset in the middle of CALC discards the op.
    set_lane(1, 32'd100, 32'd200, 2'd0, 5'd7);
    req_val = 2'b10;
    @(posedge clk); #1;
    req_val = 2'b11;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_val", resp_val, 1'b0);
    chk("midrst_rdy", req_rdy, 2'b00);
    req_val = 2'b00;
    @(negedge clk); rst_n = 1'b1;
    rr_m = 0;
    stale = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (resp_val) stale = 1'b1;
    end
    chk("no_stale", stale, 1'b0);

    // Fairness: both requesters active, grants alternate starting with 0.
    for (int k = 0; k < 4; k++) begin
      set_lane(0, rnd_val(), rnd_val(), 2'($urandom_range(0, 3)), 5'($urandom));
      set_lane(1, rnd_val(), rnd_val(), 2'($urandom_range(0, 3)), 5'($urandom));
      run_op(2'b11, 0, obs, gid);
      chk("fair_order", gid, k % 2);
    end

    for (int k = 0; k < 40; k++) begin
      logic [1:0] m;
      m = 2'($urandom_range(1, 3));
      set_lane(0, rnd_val(), rnd_val(), 2'($urandom_range(0, 3)), 5'($urandom));
      set_lane(1, rnd_val(), rnd_val(), 2'($urandom_range(0, 3)), 5'($urandom));
      run_op(m, ($urandom_range(0, 3) == 0) ? 3 : 0, obs, gid);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
